// File: rtl/soc_mem_pkg.sv
// Shared types and sizing constants for the work-RAM arbiter and its burst address generator.
package soc_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;
    // Wide enough for any MAX_WAIT in 1..15
    localparam int WAIT_W     = 4;

endpackage

// File: rtl/mem_arb_burst_gen.sv
// Video burst address walker: holds the next beat address and the beats still to issue after it.
module mem_arb_burst_gen
    import soc_mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [LEN_W-1:0]  load_len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;

    // Beat 0 goes out on the load cycle, so the stored address is already one ahead
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (load_i) begin
            cur_addr  <= load_addr_i + ADDR_W'(1);
            remaining <= load_len_i;
        end else if (step_i) begin
            cur_addr  <= cur_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign addr_o = cur_addr;
    assign last_o = (remaining == LEN_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Work-RAM arbiter: CPU single-word accesses versus prioritised display read bursts,
// with a starvation counter that forces a CPU slot after MAX_WAIT lost cycles.
module mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int LEN_W    = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  cpu_req_i,
    input  logic [MEM_BE_W-1:0]   cpu_we_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [MEM_DATA_W-1:0] cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [MEM_DATA_W-1:0] cpu_rdata_o,
    input  logic                  vid_req_i,
    input  logic [ADDR_W-1:0]     vid_addr_i,
    input  logic [LEN_W-1:0]      vid_len_i,
    output logic                  vid_ack_o,
    output logic                  vid_busy_o,
    output logic                  vid_rvalid_o,
    output logic [MEM_DATA_W-1:0] vid_rdata_o,
    output logic                  vid_last_o,
    output logic                  mem_en_o,
    output logic [MEM_BE_W-1:0]   mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [MEM_DATA_W-1:0] mem_wdata_o,
    input  logic [MEM_DATA_W-1:0] mem_rdata_i
);

    arb_state_t        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              starved;
    logic              cpu_gnt, vid_ack, vid_issue, vid_last;
    logic              bg_load, bg_step, bg_last;
    logic [ADDR_W-1:0] bg_addr;
    logic              cpu_vld_p1, vid_vld_p1, vid_last_p1;

    mem_arb_burst_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_gen (
        .clk         (clk),
        .reset_i     (reset_i),
        .load_i      (bg_load),
        .load_addr_i (vid_addr_i),
        .load_len_i  (vid_len_i),
        .step_i      (bg_step),
        .addr_o      (bg_addr),
        .last_o      (bg_last)
    );

    assign starved = cpu_req_i && (wait_cnt == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_gnt   = 1'b0;
        vid_ack   = 1'b0;
        vid_issue = 1'b0;
        vid_last  = 1'b0;
        bg_load   = 1'b0;
        bg_step   = 1'b0;
        case (state)
            IDLE: begin
                if (starved || (cpu_req_i && !vid_req_i)) begin
                    cpu_gnt = 1'b1;
                end else if (vid_req_i) begin
                    vid_ack   = 1'b1;
                    vid_issue = 1'b1;
                    bg_load   = 1'b1;
                    vid_last  = (vid_len_i == '0);
                    if (vid_len_i != '0) begin
                        state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                // A forced CPU slot only pauses the burst; the walker holds its place
                if (starved) begin
                    cpu_gnt = 1'b1;
                end else begin
                    vid_issue = 1'b1;
                    bg_step   = 1'b1;
                    vid_last  = bg_last;
                    if (bg_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = '0;
        mem_wdata_o = '0;
        if (cpu_gnt) begin
            mem_addr_o  = cpu_addr_i;
            mem_we_o    = cpu_we_i & {MEM_BE_W{reset_i}};
            mem_wdata_o = cpu_wdata_i;
        end else if (vid_ack) begin
            mem_addr_o = vid_addr_i;
        end else if (vid_issue) begin
            mem_addr_o = bg_addr;
        end
    end

    // Handshakes are qualified by reset so nothing reaches the RAM while it is held
    assign cpu_gnt_o  = cpu_gnt & reset_i;
    assign vid_ack_o  = vid_ack & reset_i;
    assign vid_busy_o = (vid_ack || (state == BURST)) & reset_i;
    assign mem_en_o   = (cpu_gnt || vid_issue) & reset_i;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            wait_cnt <= '0;
        end else if (cpu_gnt) begin
            wait_cnt <= '0;
        end else if (cpu_req_i && (wait_cnt != WAIT_W'(MAX_WAIT))) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // ---- response stage p1: RAM read data returns one cycle after issue ----
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            cpu_vld_p1  <= 1'b0;
            vid_vld_p1  <= 1'b0;
            vid_last_p1 <= 1'b0;
        end else begin
            cpu_vld_p1  <= cpu_gnt && (cpu_we_i == '0);
            vid_vld_p1  <= vid_issue;
            vid_last_p1 <= vid_issue && vid_last;
        end
    end

    assign cpu_rvalid_o = cpu_vld_p1;
    assign cpu_rdata_o  = mem_rdata_i;
    assign vid_rvalid_o = vid_vld_p1;
    assign vid_rdata_o  = mem_rdata_i;
    assign vid_last_o   = vid_last_p1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM preloaded with 0xA5000000|addr.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_i;
    logic        cpu_req_i;
    logic [3:0]  cpu_we_i;
    logic [9:0]  cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic        cpu_gnt_o;
    logic        cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        vid_req_i;
    logic [9:0]  vid_addr_i;
    logic [7:0]  vid_len_i;
    logic        vid_ack_o;
    logic        vid_busy_o;
    logic        vid_rvalid_o;
    logic [31:0] vid_rdata_o;
    logic        vid_last_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(
        .ADDR_W   (10),
        .LEN_W    (8),
        .MAX_WAIT (4)
    ) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_gnt_o    (cpu_gnt_o),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .vid_req_i    (vid_req_i),
        .vid_addr_i   (vid_addr_i),
        .vid_len_i    (vid_len_i),
        .vid_ack_o    (vid_ack_o),
        .vid_busy_o   (vid_busy_o),
        .vid_rvalid_o (vid_rvalid_o),
        .vid_rdata_o  (vid_rdata_o),
        .vid_last_o   (vid_last_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM; first clock edge (inside reset) fills the pattern
    logic [31:0] ram [1024];
    bit          ram_init;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int a = 0; a < 1024; a++) ram[a] <= 32'hA500_0000 | 32'(a);
            ram_init <= 1'b1;
        end else if (mem_en_o) begin
            if (mem_we_o == 4'h0) begin
                mem_rdata_i <= ram[mem_addr_o];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_a;
    int         beats;

    initial begin
        reset_i     = 1'b0;
        cpu_req_i   = 1'b1;
        cpu_we_i    = 4'h0;
        cpu_addr_i  = 10'h000;
        cpu_wdata_i = 32'h0;
        vid_req_i   = 1'b1;
        vid_addr_i  = 10'h000;
        vid_len_i   = 8'd0;
        #1;
        chk("rst_cpu_gnt",    32'(cpu_gnt_o),    32'd0);
        chk("rst_vid_ack",    32'(vid_ack_o),    32'd0);
        chk("rst_vid_busy",   32'(vid_busy_o),   32'd0);
        chk("rst_mem_en",     32'(mem_en_o),     32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid_o), 32'd0);
        chk("rst_vid_rvalid", 32'(vid_rvalid_o), 32'd0);
        chk("rst_vid_last",   32'(vid_last_o),   32'd0);
        cpu_req_i = 1'b0;
        vid_req_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset_i = 1'b1;

        // CPU write then read-back
        cyc();
        cpu_req_i = 1'b1; cpu_we_i = 4'hF; cpu_addr_i = 10'h010; cpu_wdata_i = 32'hDEADBEEF;
        #1;
        chk("wr_gnt",   32'(cpu_gnt_o),  32'd1);
        chk("wr_en",    32'(mem_en_o),   32'd1);
        chk("wr_we",    32'(mem_we_o),   32'hF);
        chk("wr_addr",  32'(mem_addr_o), 32'h010);
        chk("wr_wdata", mem_wdata_o,     32'hDEADBEEF);
        cyc();
        cpu_we_i = 4'h0;
        #1;
        chk("rd_gnt",          32'(cpu_gnt_o),    32'd1);
        chk("rd_we",           32'(mem_we_o),     32'h0);
        chk("wr_no_rvalid",    32'(cpu_rvalid_o), 32'd0);
        cyc();
        cpu_req_i = 1'b0;
        #1;
        chk("rd_rvalid", 32'(cpu_rvalid_o), 32'd1);
        chk("rd_rdata",  cpu_rdata_o,       32'hDEADBEEF);
        chk("rd_idle",   32'(mem_en_o),     32'd0);

        // Video-only 4-beat burst
        cyc();
        vid_req_i = 1'b1; vid_addr_i = 10'h100; vid_len_i = 8'd3;
        #1;
        chk("v_ack",  32'(vid_ack_o),  32'd1);
        chk("v_busy", 32'(vid_busy_o), 32'd1);
        chk("v_addr0", 32'(mem_addr_o), 32'h100);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            vid_req_i = 1'b0;
            #1;
            if (i < 4) begin
                chk("v_addr", 32'(mem_addr_o), 32'h100 + 32'(i));
                chk("v_ack_low", 32'(vid_ack_o), 32'd0);
                chk("v_busy_mid", 32'(vid_busy_o), 32'd1);
            end else begin
                chk("v_busy_end", 32'(vid_busy_o), 32'd0);
                chk("v_en_end", 32'(mem_en_o), 32'd0);
            end
            chk("v_rvalid", 32'(vid_rvalid_o), 32'd1);
            chk("v_rdata",  vid_rdata_o, 32'hA500_0100 + 32'(i - 1));
            chk("v_last",   32'(vid_last_o), 32'(i == 4));
        end
        cyc();
        #1;
        chk("v_rvalid_done", 32'(vid_rvalid_o), 32'd0);

        // 20-beat burst with CPU starving from burst cycle 1
        cyc();
        vid_req_i = 1'b1; vid_addr_i = 10'h040; vid_len_i = 8'd19;
        #1;
        chk("s_ack",   32'(vid_ack_o),  32'd1);
        chk("s_addr0", 32'(mem_addr_o), 32'h040);
        beats = 0;
        exp_a = 10'h040;
        for (int k = 1; k <= 22; k++) begin
            cyc();
            vid_req_i  = 1'b0;
            cpu_req_i  = (k <= 5);
            cpu_we_i   = 4'h0;
            cpu_addr_i = 10'h010;
            #1;
            if (k <= 4) begin
                chk("s_gnt_lost", 32'(cpu_gnt_o), 32'd0);
                chk("s_addr_pre", 32'(mem_addr_o), 32'h040 + 32'(k));
            end else if (k == 5) begin
                chk("s_gnt_forced", 32'(cpu_gnt_o), 32'd1);
                chk("s_addr_cpu",   32'(mem_addr_o), 32'h010);
                chk("s_busy_pause", 32'(vid_busy_o), 32'd1);
            end else if (k <= 20) begin
                chk("s_addr_post", 32'(mem_addr_o), 32'h040 + 32'(k - 1));
                chk("s_gnt_post",  32'(cpu_gnt_o), 32'd0);
            end else if (k == 21) begin
                chk("s_busy_end", 32'(vid_busy_o), 32'd0);
            end
            if (k == 6) begin
                chk("s_cpu_rvalid", 32'(cpu_rvalid_o), 32'd1);
                chk("s_cpu_rdata",  cpu_rdata_o, 32'hDEADBEEF);
            end
            if (vid_rvalid_o) begin
                chk("s_rdata", vid_rdata_o, 32'hA500_0000 | 32'(exp_a));
                chk("s_last",  32'(vid_last_o), 32'(exp_a == 10'h053));
                exp_a = exp_a + 10'd1;
                beats++;
            end
        end
        chk("s_beats", 32'(beats), 32'd20);

        // Simultaneous requests: wait_cnt 0, then wait_cnt at MAX_WAIT
        cyc();
        cpu_req_i = 1'b1; cpu_we_i = 4'h0; cpu_addr_i = 10'h012;
        vid_req_i = 1'b1; vid_addr_i = 10'h080; vid_len_i = 8'd3;
        #1;
        chk("m_ack0", 32'(vid_ack_o), 32'd1);
        chk("m_gnt0", 32'(cpu_gnt_o), 32'd0);
        chk("m_addr0", 32'(mem_addr_o), 32'h080);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            vid_req_i = 1'b0;
            #1;
            chk("m_gnt_wait", 32'(cpu_gnt_o), 32'd0);
            chk("m_addr", 32'(mem_addr_o), 32'h080 + 32'(i));
        end
        cyc();
        vid_req_i = 1'b1; vid_addr_i = 10'h0C0; vid_len_i = 8'd0;
        #1;
        chk("m_gnt_starved", 32'(cpu_gnt_o), 32'd1);
        chk("m_ack_defer",   32'(vid_ack_o), 32'd0);
        chk("m_addr_cpu",    32'(mem_addr_o), 32'h012);
        chk("m_last_beat",   32'(vid_last_o), 32'd1);
        chk("m_last_rdata",  vid_rdata_o, 32'hA500_0083);
        cyc();
        cpu_req_i = 1'b0;
        #1;
        chk("m_ack1",      32'(vid_ack_o), 32'd1);
        chk("m_gnt1",      32'(cpu_gnt_o), 32'd0);
        chk("m_addr1",     32'(mem_addr_o), 32'h0C0);
        chk("m_busy1",     32'(vid_busy_o), 32'd1);
        chk("m_cpu_rdata", cpu_rdata_o, 32'hA500_0012);
        chk("m_cpu_rvld",  32'(cpu_rvalid_o), 32'd1);
        cyc();
        vid_req_i = 1'b0;
        #1;
        chk("m_busy_len0", 32'(vid_busy_o), 32'd0);
        chk("m_rvld_len0", 32'(vid_rvalid_o), 32'd1);
        chk("m_last_len0", 32'(vid_last_o), 32'd1);
        chk("m_rd_len0",   vid_rdata_o, 32'hA500_00C0);

        // Address wrap at the top of the RAM
        cyc();
        vid_req_i = 1'b1; vid_addr_i = 10'h3FE; vid_len_i = 8'd3;
        #1;
        chk("w_addr0", 32'(mem_addr_o), 32'h3FE);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            vid_req_i = 1'b0;
            #1;
            exp_a = 10'h3FE + 10'(i);
            chk("w_addr", 32'(mem_addr_o), 32'(exp_a));
        end
        chk("w_rdata_wrap", vid_rdata_o, 32'hA500_0000);
        cyc();
        #1;
        chk("w_rdata_last", vid_rdata_o, 32'hA500_0001);
        chk("w_last",       32'(vid_last_o), 32'd1);

        // Reset in the middle of a 10-beat burst
        cyc();
        vid_req_i = 1'b1; vid_addr_i = 10'h300; vid_len_i = 8'd9;
        #1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            vid_req_i = 1'b0;
            #1;
            chk("r_addr", 32'(mem_addr_o), 32'h300 + 32'(i));
        end
        reset_i = 1'b0;
        #1;
        chk("r_async_en",     32'(mem_en_o),     32'd0);
        chk("r_async_busy",   32'(vid_busy_o),   32'd0);
        chk("r_async_rvalid", 32'(vid_rvalid_o), 32'd0);
        chk("r_async_last",   32'(vid_last_o),   32'd0);
        cyc();
        #1;
        chk("r_hold_en", 32'(mem_en_o), 32'd0);
        cyc();
        #2 reset_i = 1'b1;
        #1;
        chk("r_rel_en",   32'(mem_en_o),   32'd0);
        chk("r_rel_busy", 32'(vid_busy_o), 32'd0);
        cyc();
        #1;
        chk("r_no_stray", 32'(vid_rvalid_o), 32'd0);
        chk("r_idle_en",  32'(mem_en_o),     32'd0);
        cyc();
        vid_req_i = 1'b1; vid_addr_i = 10'h200; vid_len_i = 8'd1;
        #1;
        chk("r_new_ack",  32'(vid_ack_o),  32'd1);
        chk("r_new_addr", 32'(mem_addr_o), 32'h200);
        cyc();
        vid_req_i = 1'b0;
        #1;
        chk("r_new_addr1", 32'(mem_addr_o), 32'h201);
        chk("r_new_rd0",   vid_rdata_o, 32'hA500_0200);
        cyc();
        #1;
        chk("r_new_rd1",  vid_rdata_o, 32'hA500_0201);
        chk("r_new_last", 32'(vid_last_o), 32'd1);
        chk("r_new_busy", 32'(vid_busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
